// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and helpers for pwm_multi_ch.
//   CNT_W_DEF  - default counter width
//   fade_dir_t - breathing direction
//   sat_add / sat_sub - saturating level arithmetic, one bit wider than any
//                       supported counter so lvl+step never wraps
package pwm_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned CNT_W_MAX = 32;

  typedef logic [CNT_W_MAX:0] lvl_wide_t;

  typedef enum logic {FADE_UP, FADE_DOWN} fade_dir_t;

  // min(a + b, lim)
  function automatic lvl_wide_t sat_add(input lvl_wide_t a, input lvl_wide_t b,
                                        input lvl_wide_t lim);
    lvl_wide_t s;
    s = a + b;
    return (s > lim) ? lim : s;
  endfunction

  // a - b, floored at zero
  function automatic lvl_wide_t sat_sub(input lvl_wide_t a, input lvl_wide_t b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/pwm_fade_lvl.sv
// pwm_fade_lvl: per-channel triangle fade level.
//   clk, rst_n - clock, async active-low reset
//   en         - run enable (level forced to 0 when low)
//   fade_en    - channel fade mode (level forced to 0 when low)
//   wrap       - period boundary strobe (already qualified by en)
//   step       - level increment per period
//   duty       - fade ceiling
//   lvl        - current fade level
module pwm_fade_lvl
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fade_en,
  input  logic             wrap,
  input  logic [CNT_W-1:0] step,
  input  logic [CNT_W-1:0] duty,
  output logic [CNT_W-1:0] lvl
);

  fade_dir_t        dir;
  lvl_wide_t        up_w;
  lvl_wide_t        dn_w;
  logic [CNT_W-1:0] up_v;
  logic [CNT_W-1:0] dn_v;

  always_comb begin
    up_w = sat_add(lvl_wide_t'(lvl), lvl_wide_t'(step), lvl_wide_t'(duty));
    dn_w = sat_sub(lvl_wide_t'(lvl), lvl_wide_t'(step));
    up_v = up_w[CNT_W-1:0];
    dn_v = dn_w[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl <= '0;
      dir <= FADE_UP;
    end else if (!(en && fade_en)) begin
      lvl <= '0;
      dir <= FADE_UP;
    end else if (wrap) begin
      // a freshly applied ceiling below the current level pulls it down at once
      if (lvl > duty) begin
        lvl <= duty;
        dir <= FADE_DOWN;
      end else if (dir == FADE_UP) begin
        lvl <= up_v;
        if (up_w == lvl_wide_t'(duty)) dir <= FADE_DOWN;
      end else begin
        lvl <= dn_v;
        if (dn_w == '0) dir <= FADE_UP;
      end
    end
  end

endmodule

// File: rtl/pwm_multi_ch.sv
// pwm_multi_ch: multi-channel PWM with double-buffered config and optional fade.
//   clk, rst_n     - clock, async active-low reset
//   en             - run enable; 0 holds counter at 0, outputs idle
//   cfg_valid/ready- config handshake; accepted config waits for a period boundary
//   cfg_period     - period length minus 1
//   cfg_duty       - per-channel high-cycle count, channel i at [i*CNT_W +: CNT_W]
//   cfg_fade_en    - per-channel fade enable
//   cfg_fade_step  - fade increment per period
//   pwm_out        - registered outputs, bit i inverted when INV[i]
//   period_end     - one-cycle pulse after the last cycle of each period
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int unsigned       CH_NUM = 3,
  parameter int unsigned       CNT_W  = CNT_W_DEF,
  parameter logic [CH_NUM-1:0] INV    = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [CH_NUM*CNT_W-1:0] cfg_duty,
  input  logic [CH_NUM-1:0]       cfg_fade_en,
  input  logic [CNT_W-1:0]        cfg_fade_step,
  output logic [CH_NUM-1:0]       pwm_out,
  output logic                    period_end
);

  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        period_a;
  logic [CNT_W-1:0]        step_a;
  logic [CH_NUM*CNT_W-1:0] duty_a;
  logic [CH_NUM-1:0]       fade_a;

  logic [CNT_W-1:0]        pend_period;
  logic [CNT_W-1:0]        pend_step;
  logic [CH_NUM*CNT_W-1:0] pend_duty;
  logic [CH_NUM-1:0]       pend_fade;
  logic                    pend_flag;

  logic [CH_NUM*CNT_W-1:0] lvl_all;
  logic [CH_NUM-1:0]       hit;
  logic                    wrap;
  logic                    accept;
  logic                    apply;

  always_comb begin
    wrap   = en && (cnt == period_a);
    accept = cfg_valid && cfg_ready;
    // while stopped there is no boundary to wait for
    apply  = pend_flag && (wrap || !en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // accept and apply are exclusive: cfg_ready mirrors !pend_flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_period <= '0;
      pend_step   <= '0;
      pend_duty   <= '0;
      pend_fade   <= '0;
      pend_flag   <= 1'b0;
      cfg_ready   <= 1'b1;
    end else if (accept) begin
      pend_period <= cfg_period;
      pend_step   <= cfg_fade_step;
      pend_duty   <= cfg_duty;
      pend_fade   <= cfg_fade_en;
      pend_flag   <= 1'b1;
      cfg_ready   <= 1'b0;
    end else if (apply) begin
      pend_flag   <= 1'b0;
      cfg_ready   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_a <= '0;
      step_a   <= '0;
      duty_a   <= '0;
      fade_a   <= '0;
    end else if (apply) begin
      period_a <= pend_period;
      step_a   <= pend_step;
      duty_a   <= pend_duty;
      fade_a   <= pend_fade;
    end
  end

  for (genvar i = 0; i < int'(CH_NUM); i++) begin : g_ch
    logic [CNT_W-1:0] deff;

    pwm_fade_lvl #(
      .CNT_W(CNT_W)
    ) u_fade (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .fade_en(fade_a[i]),
      .wrap   (wrap),
      .step   (step_a),
      .duty   (duty_a[i*CNT_W +: CNT_W]),
      .lvl    (lvl_all[i*CNT_W +: CNT_W])
    );

    always_comb begin
      deff   = fade_a[i] ? lvl_all[i*CNT_W +: CNT_W] : duty_a[i*CNT_W +: CNT_W];
      hit[i] = en && (cnt < deff);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out    <= INV;
      period_end <= 1'b0;
    end else begin
      pwm_out    <= hit ^ INV;
      period_end <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
module tb_pwm_multi_ch;

  localparam logic [2:0] INV_M = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_period;
  logic [47:0] cfg_duty;
  logic [2:0]  cfg_fade_en;
  logic [15:0] cfg_fade_step;
  logic [2:0]  pwm_out;
  logic        period_end;

  int total = 0;
  int bad   = 0;

  pwm_multi_ch #(
    .CH_NUM(3),
    .CNT_W (16),
    .INV   (INV_M)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_duty     (cfg_duty),
    .cfg_fade_en  (cfg_fade_en),
    .cfg_fade_step(cfg_fade_step),
    .pwm_out      (pwm_out),
    .period_end   (period_end)
  );

  always #5 clk = ~clk;

  // Reference model: active/pending config, fade levels, expected outputs
  int       m_cnt, m_per, m_step, p_per, p_step;
  int       m_duty[3], p_duty[3], m_lvl[3];
  bit       m_fade[3], p_fade[3], m_down[3];
  bit       m_pend;
  logic [2:0] e_pwm;
  logic       e_pe, e_ready;

  task automatic model_reset();
    m_cnt = 0; m_per = 0; m_step = 0; p_per = 0; p_step = 0; m_pend = 0;
    for (int i = 0; i < 3; i++) begin
      m_duty[i] = 0; p_duty[i] = 0; m_lvl[i] = 0;
      m_fade[i] = 0; p_fade[i] = 0; m_down[i] = 0;
    end
    e_pwm = INV_M; e_pe = 1'b0; e_ready = 1'b1;
  endtask

  task automatic model_step();
    bit wrap, acc, apply;
    int deff;
    logic [2:0] inv_v;
    if (!rst_n) begin
      model_reset();
      return;
    end
    inv_v = INV_M;
    wrap  = en && (m_cnt == m_per);
    acc   = cfg_valid && e_ready;
    apply = m_pend && (wrap || !en);
    for (int i = 0; i < 3; i++) begin
      deff = m_fade[i] ? m_lvl[i] : m_duty[i];
      e_pwm[i] = ((en && (m_cnt < deff)) ? 1'b1 : 1'b0) ^ inv_v[i];
    end
    e_pe = wrap;
    for (int i = 0; i < 3; i++) begin
      if (!m_fade[i] || !en) begin
        m_lvl[i] = 0; m_down[i] = 0;
      end else if (wrap) begin
        if (m_lvl[i] > m_duty[i]) begin
          m_lvl[i] = m_duty[i]; m_down[i] = 1;
        end else if (!m_down[i]) begin
          m_lvl[i] = (m_lvl[i] + m_step > m_duty[i]) ? m_duty[i] : m_lvl[i] + m_step;
          if (m_lvl[i] == m_duty[i]) m_down[i] = 1;
        end else begin
          m_lvl[i] = (m_lvl[i] > m_step) ? m_lvl[i] - m_step : 0;
          if (m_lvl[i] == 0) m_down[i] = 0;
        end
      end
    end
    m_cnt = (!en || wrap) ? 0 : m_cnt + 1;
    if (apply) begin
      m_per = p_per; m_step = p_step; m_pend = 0;
      for (int i = 0; i < 3; i++) begin
        m_duty[i] = p_duty[i]; m_fade[i] = p_fade[i];
      end
    end
    if (acc) begin
      p_per = int'(cfg_period); p_step = int'(cfg_fade_step); m_pend = 1;
      for (int i = 0; i < 3; i++) begin
        p_duty[i] = int'(cfg_duty[i*16 +: 16]);
        p_fade[i] = cfg_fade_en[i];
      end
    end
    e_ready = !m_pend;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_cfg(input int per, input logic [47:0] duty, input logic [2:0] fe,
                         input int step);
    cfg_period = 16'(per); cfg_duty = duty; cfg_fade_en = fe; cfg_fade_step = 16'(step);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    set_cfg(0, '0, '0, 0);
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (pwm_out !== 3'b001 || cfg_ready !== 1'b1 || period_end !== 1'b0) begin
        bad++;
        $display("FAIL reset_vals: pwm=%b rdy=%b pe=%b want pwm=001 rdy=1 pe=0",
                 pwm_out, cfg_ready, period_end);
      end
    end
    rst_n = 1'b1;
    tick();
    total++;
    if ({pwm_out, period_end, cfg_ready} !== {e_pwm, e_pe, e_ready}) begin
      bad++;
      $display("FAIL reset_model: pwm=%b pe=%b rdy=%b want %b %b %b",
               pwm_out, period_end, cfg_ready, e_pwm, e_pe, e_ready);
    end
  endtask

  task automatic test_basic();
    int  h0, h1, h2, pe_n;
    bit  seen;
    en = 1'b1;
    set_cfg(9, {16'd10, 16'd5, 16'd0}, 3'b000, 0);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 5 && !seen; k++) begin
      tick();
      if (period_end) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL basic_sync: period_end not seen within 5 cycles, want 1");
    end
    for (int p = 0; p < 3; p++) begin
      h0 = 0; h1 = 0; h2 = 0; pe_n = 0;
      for (int c = 0; c < 10; c++) begin
        tick();
        total++;
        if ({pwm_out, period_end, cfg_ready} !== {e_pwm, e_pe, e_ready}) begin
          bad++;
          $display("FAIL basic_model: pwm=%b pe=%b rdy=%b want %b %b %b",
                   pwm_out, period_end, cfg_ready, e_pwm, e_pe, e_ready);
        end
        h0 += int'(pwm_out[0]); h1 += int'(pwm_out[1]); h2 += int'(pwm_out[2]);
        pe_n += int'(period_end);
      end
      total++;
      if (h0 != 10 || h1 != 5 || h2 != 10 || pe_n != 1 || period_end !== 1'b1) begin
        bad++;
        $display("FAIL basic_counts: h0=%0d h1=%0d h2=%0d pe=%0d last_pe=%b want 10 5 10 1 1",
                 h0, h1, h2, pe_n, period_end);
      end
    end
  endtask

  task automatic test_midperiod();
    int h1;
    h1 = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        set_cfg(9, {16'd10, 16'd2, 16'd0}, 3'b000, 0);
        cfg_valid = 1'b1;
      end
      tick();
      if (c == 3) begin
        cfg_valid = 1'b0;
        total++;
        if (cfg_ready !== 1'b0) begin
          bad++;
          $display("FAIL mid_ready_drop: rdy=%b want 0", cfg_ready);
        end
      end
      total++;
      if ({pwm_out, period_end, cfg_ready} !== {e_pwm, e_pe, e_ready}) begin
        bad++;
        $display("FAIL mid_model: pwm=%b pe=%b rdy=%b want %b %b %b",
                 pwm_out, period_end, cfg_ready, e_pwm, e_pe, e_ready);
      end
      h1 += int'(pwm_out[1]);
    end
    total++;
    if (h1 != 5 || period_end !== 1'b1 || cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_old_period: h1=%0d pe=%b rdy=%b want 5 1 1", h1, period_end, cfg_ready);
    end
    h1 = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      h1 += int'(pwm_out[1]);
    end
    total++;
    if (h1 != 2 || period_end !== 1'b1) begin
      bad++;
      $display("FAIL mid_new_period: h1=%0d pe=%b want 2 1", h1, period_end);
    end
  endtask

  task automatic test_wrap_offer();
    int h1;
    for (int c = 0; c < 9; c++) tick();
    set_cfg(9, {16'd10, 16'd7, 16'd0}, 3'b000, 0);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    total++;
    if (period_end !== 1'b1 || cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL wrap_accept: pe=%b rdy=%b want 1 0", period_end, cfg_ready);
    end
    for (int p = 0; p < 2; p++) begin
      h1 = 0;
      for (int c = 0; c < 10; c++) begin
        tick();
        total++;
        if ({pwm_out, period_end, cfg_ready} !== {e_pwm, e_pe, e_ready}) begin
          bad++;
          $display("FAIL wrap_model: pwm=%b pe=%b rdy=%b want %b %b %b",
                   pwm_out, period_end, cfg_ready, e_pwm, e_pe, e_ready);
        end
        h1 += int'(pwm_out[1]);
      end
      total++;
      if (h1 != ((p == 0) ? 2 : 7) || cfg_ready !== 1'b1) begin
        bad++;
        $display("FAIL wrap_period%0d: h1=%0d rdy=%b want %0d 1", p, h1, cfg_ready,
                 (p == 0) ? 2 : 7);
      end
    end
  endtask

  task automatic test_fade();
    int  exp_f[12] = '{0, 2, 4, 6, 4, 2, 0, 2, 4, 6, 6, 6};
    int  lo;
    bit  seen;
    set_cfg(9, {16'd10, 16'd5, 16'd6}, 3'b001, 2);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 15 && !seen; k++) begin
      tick();
      if (period_end && cfg_ready) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL fade_sync: apply not seen within 15 cycles, want 1");
    end
    for (int p = 0; p < 12; p++) begin
      lo = 0;
      for (int c = 0; c < 10; c++) begin
        if (p == 8 && c == 0) begin
          set_cfg(9, {16'd10, 16'd5, 16'd6}, 3'b001, 0);
          cfg_valid = 1'b1;
        end
        tick();
        cfg_valid = 1'b0;
        total++;
        if ({pwm_out, period_end, cfg_ready} !== {e_pwm, e_pe, e_ready}) begin
          bad++;
          $display("FAIL fade_model: pwm=%b pe=%b rdy=%b want %b %b %b",
                   pwm_out, period_end, cfg_ready, e_pwm, e_pe, e_ready);
        end
        lo += int'(!pwm_out[0]);
      end
      total++;
      if (lo != exp_f[p]) begin
        bad++;
        $display("FAIL fade_period%0d: active=%0d want %0d", p, lo, exp_f[p]);
      end
    end
  endtask

  task automatic test_period_zero();
    bit seen;
    set_cfg(0, {16'd1, 16'd1, 16'd0}, 3'b000, 0);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 15 && !seen; k++) begin
      tick();
      if (period_end && cfg_ready) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL pz_sync: apply not seen within 15 cycles, want 1");
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      total++;
      if (pwm_out !== 3'b111 || period_end !== 1'b1) begin
        bad++;
        $display("FAIL pz_const: pwm=%b pe=%b want 111 1", pwm_out, period_end);
      end
    end
  endtask

  task automatic test_reset_pending();
    set_cfg(9, {16'd10, 16'd5, 16'd0}, 3'b000, 0);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    set_cfg(4, {16'd3, 16'd3, 16'd3}, 3'b111, 1);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    total++;
    if (cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL rp_pending: rdy=%b want 0", cfg_ready);
    end
    tick(); tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (pwm_out !== 3'b001 || cfg_ready !== 1'b1 || period_end !== 1'b0) begin
      bad++;
      $display("FAIL rp_async: pwm=%b rdy=%b pe=%b want 001 1 0", pwm_out, cfg_ready, period_end);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      total++;
      if (pwm_out !== 3'b001 || cfg_ready !== 1'b1 ||
          {pwm_out, period_end, cfg_ready} !== {e_pwm, e_pe, e_ready}) begin
        bad++;
        $display("FAIL rp_discard: pwm=%b pe=%b rdy=%b want %b %b 1",
                 pwm_out, period_end, cfg_ready, e_pwm, e_pe);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 30) == 0) en = ~en;
      cfg_valid = ($urandom_range(0, 5) == 0);
      set_cfg($urandom_range(0, 12),
              {16'($urandom_range(0, 14)), 16'($urandom_range(0, 14)),
               16'($urandom_range(0, 14))},
              3'($urandom_range(0, 7)), $urandom_range(0, 4));
      tick();
      total++;
      if ({pwm_out, period_end, cfg_ready} !== {e_pwm, e_pe, e_ready}) begin
        bad++;
        $display("FAIL rand_model: cyc=%0d pwm=%b pe=%b rdy=%b want %b %b %b",
                 c, pwm_out, period_end, cfg_ready, e_pwm, e_pe, e_ready);
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midperiod();
    test_wrap_offer();
    test_fade();
    test_period_zero();
    test_reset_pending();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
